multicycle_adder: RTL and testbench

Parametrised multi-cycle ripple adder. Adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, keeping a registered carry between chunks. Uses a valid/ready handshake on input and output, plus a `block` stall input. Successor to the registered 1-bit full adder; used wherever wide sums can trade latency for area.

---
 rtl/multicycle_adder_pkg.sv | 26 ++
 rtl/multicycle_adder_chunk.sv | 37 +++
 rtl/multicycle_adder.sv | 179 +++++++++++++++++
 tb/tb_multicycle_adder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_adder_pkg.sv
// Shared types and elaboration helpers for the multi-cycle ripple adder.
//
// Contents:
//   state_t  - controller states (IDLE, RUN, DONE)
//   nch()    - number of CHUNK-bit slices in a WIDTH-bit operand
//   cnt_w()  - slice counter width, never less than one bit
package multicycle_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nch(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic int cnt_w(input int n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/multicycle_adder_chunk.sv
// Combinational CHUNK-bit adder slice with carry in/out.
//
// Optional build macro: MULTICYCLE_ADDER_OVF_EN adds msb_cin, the carry
// into the slice's top bit, used for signed overflow detection.
//
// Ports:
//   a, b     in   CHUNK  slice operands
//   cin      in   1      carry into bit 0
//   s        out  CHUNK  slice sum
//   cout     out  1      carry out of the top bit
//   msb_cin  out  1      carry into the top bit (MULTICYCLE_ADDER_OVF_EN only)
module adder_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
`ifdef MULTICYCLE_ADDER_OVF_EN
    ,output logic            msb_cin
`endif
);

    logic [CHUNK:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign s     = total[CHUNK-1:0];
    assign cout  = total[CHUNK];

`ifdef MULTICYCLE_ADDER_OVF_EN
    // The sum bit is a ^ b ^ carry_in, so the carry into the top bit falls
    // out of the top bits without a second partial adder.
    assign msb_cin = a[CHUNK-1] ^ b[CHUNK-1] ^ total[CHUNK-1];
`endif

endmodule

// File: rtl/multicycle_adder.sv
// Multi-cycle ripple adder: adds a + b + cin, CHUNK bits per clock, LSB
// slice first, with the inter-slice carry held in a register.
//
// Optional build macro: MULTICYCLE_ADDER_OVF_EN adds the ovf output
// (signed two's-complement overflow, registered alongside cout).
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-low reset
//   in_valid   in   1      a/b/cin valid
//   in_ready   out  1      operands can be accepted
//   a, b       in   WIDTH  operands
//   cin        in   1      carry-in
//   block      in   1      stall: freezes accept and computation
//   out_valid  out  1      sum/cout hold a result not yet taken
//   out_ready  in   1      consumer takes the result
//   sum        out  WIDTH  registered result (mod 2^WIDTH)
//   cout       out  1      registered carry-out of the MSB
//   ovf        out  1      signed overflow (MULTICYCLE_ADDER_OVF_EN only)
//
// state | meaning
// IDLE  | waiting for operands; in_ready = ~block
// RUN   | adding one slice per unblocked cycle
// DONE  | result presented until out_ready
module multicycle_adder
    import multicycle_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             block,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef MULTICYCLE_ADDER_OVF_EN
    ,output logic            ovf
`endif
);

    localparam int NCH = nch(WIDTH, CHUNK);
    localparam int CW  = cnt_w(NCH);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("multicycle_adder: WIDTH must be a multiple of CHUNK");
    end

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  op_a_q, op_a_d;
    logic [WIDTH-1:0]  op_b_q, op_b_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              out_valid_q, out_valid_d;

    logic [CHUNK-1:0]  slice_a, slice_b, slice_s;
    logic              slice_c;

`ifdef MULTICYCLE_ADDER_OVF_EN
    logic              ovf_q, ovf_d;
    logic              slice_msb_cin;
`endif

    assign slice_a = op_a_q[int'(cnt_q)*CHUNK +: CHUNK];
    assign slice_b = op_b_q[int'(cnt_q)*CHUNK +: CHUNK];

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a       (slice_a),
        .b       (slice_b),
        .cin     (carry_q),
        .s       (slice_s),
        .cout    (slice_c)
`ifdef MULTICYCLE_ADDER_OVF_EN
        ,.msb_cin(slice_msb_cin)
`endif
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef MULTICYCLE_ADDER_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
`ifdef MULTICYCLE_ADDER_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        acc_d       = acc_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;
        in_ready    = 1'b0;
`ifdef MULTICYCLE_ADDER_OVF_EN
        ovf_d       = ovf_q;
`endif

        case (state_q)
            IDLE: begin
                in_ready = ~block;
                if (in_valid && !block) begin
                    op_a_d  = a;
                    op_b_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!block) begin
                    acc_d[int'(cnt_q)*CHUNK +: CHUNK] = slice_s;
                    carry_d = slice_c;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(NCH - 1)) begin
                        // acc_d already carries the final slice here
                        sum_d       = acc_d;
                        cout_d      = slice_c;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
`ifdef MULTICYCLE_ADDER_OVF_EN
                        ovf_d       = slice_msb_cin ^ slice_c;
`endif
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef MULTICYCLE_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_multicycle_adder.sv
// Self-checking bench for multicycle_adder: a WIDTH=16/CHUNK=4 instance for
// the main sequences and a CHUNK=16 instance for the single-slice case.
// Expected results come from plain integer arithmetic on the operands.
module tb_multicycle_adder;

    localparam int W   = 16;
    localparam int NCH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    always #5 clk = ~clk;

    logic          in_valid = 1'b0, in_ready, cin = 1'b0, block = 1'b0;
    logic          out_valid, out_ready = 1'b0, cout;
    logic [W-1:0]  a = '0, b = '0, sum;

    logic          x_in_valid = 1'b0, x_in_ready, x_cin = 1'b0, x_block = 1'b0;
    logic          x_out_valid, x_out_ready = 1'b0, x_cout;
    logic [W-1:0]  x_a = '0, x_b = '0, x_sum;

`ifdef MULTICYCLE_ADDER_OVF_EN
    logic          ovf, x_ovf;
`endif

    multicycle_adder #(.WIDTH(W), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .block(block), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef MULTICYCLE_ADDER_OVF_EN
        ,.ovf(ovf)
`endif
    );

    multicycle_adder #(.WIDTH(W), .CHUNK(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(x_in_valid), .in_ready(x_in_ready),
        .a(x_a), .b(x_b), .cin(x_cin), .block(x_block), .out_valid(x_out_valid),
        .out_ready(x_out_ready), .sum(x_sum), .cout(x_cout)
`ifdef MULTICYCLE_ADDER_OVF_EN
        ,.ovf(x_ovf)
`endif
    );

    int checks = 0;
    int errors = 0;
    logic [W-1:0] last_sum  = '0;
    logic         last_cout = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                           input logic rc);
        int unsigned t;
        t = int'(ra) + int'(rb) + int'(rc);
        return t[W:0];
    endfunction

`ifdef MULTICYCLE_ADDER_OVF_EN
    function automatic logic ref_ovf(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                     input logic rc);
        int sv;
        sv = int'($signed(ra)) + int'($signed(rb)) + int'(rc);
        return (sv > 32767) || (sv < -32768);
    endfunction
`endif

    // One operation on the CHUNK=4 instance. Block is raised before edges
    // blk_after .. blk_after+blk_len-1 counted from the accept edge; the
    // result is then held unconsumed for `hold` cycles.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic tc,
                          input int blk_after, input int blk_len, input int hold);
        logic [W:0] exp;
        int n;
        exp = ref_add(ta, tb2, tc);
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        a = ta; b = tb2; cin = tc; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        chk("in_ready_run", 32'(in_ready), 32'd0);
        chk("sum_hold_run", 32'(sum), 32'(last_sum));
        chk("cout_hold_run", 32'(cout), 32'(last_cout));
        n = 0;
        do begin
            n++;
            block = (n >= blk_after) && (n < blk_after + blk_len);
            tick();
        end while (!out_valid && n < 60);
        block = 1'b0;
        chk("latency", 32'(n), 32'(NCH + blk_len));
        chk("sum", 32'(sum), 32'(exp[W-1:0]));
        chk("cout", 32'(cout), 32'(exp[W]));
`ifdef MULTICYCLE_ADDER_OVF_EN
        chk("ovf", 32'(ovf), 32'(ref_ovf(ta, tb2, tc)));
`endif
        for (int i = 0; i < hold; i++) begin
            block = 1'($urandom);
            tick();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_sum", 32'(sum), 32'(exp[W-1:0]));
            chk("hold_cout", 32'(cout), 32'(exp[W]));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        block = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("take_valid", 32'(out_valid), 32'd0);
        chk("take_in_ready", 32'(in_ready), 32'd1);
        last_sum  = exp[W-1:0];
        last_cout = exp[W];
    endtask

    task automatic run16(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic tc);
        logic [W:0] exp;
        exp = ref_add(ta, tb2, tc);
        chk("x_in_ready", 32'(x_in_ready), 32'd1);
        x_a = ta; x_b = tb2; x_cin = tc; x_in_valid = 1'b1;
        tick();
        x_in_valid = 1'b0;
        chk("x_run_valid", 32'(x_out_valid), 32'd0);
        tick();
        chk("x_valid", 32'(x_out_valid), 32'd1);
        chk("x_sum", 32'(x_sum), 32'(exp[W-1:0]));
        chk("x_cout", 32'(x_cout), 32'(exp[W]));
`ifdef MULTICYCLE_ADDER_OVF_EN
        chk("x_ovf", 32'(x_ovf), 32'(ref_ovf(ta, tb2, tc)));
`endif
        x_out_ready = 1'b1;
        tick();
        x_out_ready = 1'b0;
        chk("x_taken", 32'(x_out_valid), 32'd0);
    endtask

    initial begin
        logic seen;
        logic [W-1:0] ra, rb;

        // reset state while rst is held low
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef MULTICYCLE_ADDER_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        #10 rst = 1'b1;
        tick();

        // carry ripples through every slice
        run_op(16'hFFFF, 16'h0001, 1'b0, 1, 0, 0);
        // stall for 3 cycles while counter==2, then hold result 5 cycles
        run_op(16'h1234, 16'h1111, 1'b1, 3, 3, 5);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1, 0, 1);
        run_op(16'h8000, 16'h8000, 1'b1, 2, 1, 0);

        // block in IDLE: no accept
        block = 1'b1; in_valid = 1'b1; a = 16'h0F0F; b = 16'h0101;
        #1;
        chk("idle_block_ready", 32'(in_ready), 32'd0);
        tick(); tick();
        in_valid = 1'b0; block = 1'b0;
        #1;
        chk("idle_block_no_accept", 32'(in_ready), 32'd1);
        chk("idle_block_no_valid", 32'(out_valid), 32'd0);

        // reset mid-RUN with counter==1 discards the operation
        a = 16'h4321; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #1 rst = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        #2 rst = 1'b1;
        last_sum = '0; last_cout = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | out_valid;
        end
        chk("midrst_no_output", 32'(seen), 32'd0);
        run_op(16'h4321, 16'h1111, 1'b0, 1, 0, 0);

        // randomized operations
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(ra, rb, 1'($urandom), int'($urandom_range(1, NCH)),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        // single-slice instance
        run16(16'h8000, 16'h8000, 1'b0);
        run16(16'h7FFF, 16'h0001, 1'b0);
        run16(16'hFFFF, 16'h0001, 1'b0);
        for (int i = 0; i < 5; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run16(ra, rb, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
